// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader: FSM encodings, halt word, default depth.
package carregador_programa_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ACC   = 4'd1,
    WR    = 4'd2,
    TERM  = 4'd3,
    START = 4'd4,
    DONE  = 4'd5,
    ERR   = 4'd6
  } estado_t;

  localparam logic [31:0] INSTR_HALT    = 32'h0000_0000;
  localparam int          MEM_WORDS_DEF = 32;

endpackage

// File: rtl/carregador_programa_montador_palavra.sv
// Little-endian word assembler: shifts accepted bytes into a 32-bit register,
// tracks the byte index and remembers whether the last byte carried in_last.
module montador_palavra
  import carregador_programa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  input  logic        last_in,
  output logic [31:0] word,
  output logic [2:0]  idx,
  output logic        full,
  output logic        last
);

  assign full = idx[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= INSTR_HALT;
      idx  <= '0;
      last <= 1'b0;
    end else if (clr) begin
      word <= INSTR_HALT;
      idx  <= '0;
      last <= 1'b0;
    end else if (push && !full) begin
      word[{idx[1:0], 3'b000} +: 8] <= byte_in;
      idx  <= idx + 3'd1;
      last <= last_in;
    end
  end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: byte stream -> instruction memory words, halt terminator, core_start pulse.
// Optional build macro CARREGADOR_CHECKSUM_EN adds a trailing XOR checksum word and error_checksum.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_start,
  output logic [ADDR_W:0]   loaded_words,
  output logic              error_overflow,
  output logic              busy
`ifdef CARREGADOR_CHECKSUM_EN
  ,
  output logic              error_checksum
`endif
);

  localparam logic [ADDR_W:0] CAPACIDADE = (ADDR_W+1)'(MEM_WORDS);

  estado_t         estado, prox;
  logic [ADDR_W:0] end_pal;
  logic [31:0]     palavra;
  logic [2:0]      idx;
  logic            cheio, ultimo;
  logic            aceita, limpa, grava, set_ovf, set_chk;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [31:0]     acc_xor;
`endif

  assign aceita       = in_valid && in_ready;
  assign imem_addr    = end_pal[ADDR_W-1:0];
  assign loaded_words = end_pal;

  montador_palavra u_montador (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (limpa),
    .push    (aceita),
    .byte_in (in_byte),
    .last_in (in_last),
    .word    (palavra),
    .idx     (idx),
    .full    (cheio),
    .last    (ultimo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= prox;
  end

  always_comb begin
    prox       = estado;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = palavra;
    limpa      = 1'b0;
    grava      = 1'b0;
    set_ovf    = 1'b0;
    set_chk    = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;
    case (estado)
      IDLE: begin
        in_ready = !cheio;
        if (in_valid) prox = in_last ? WR : ACC;
      end
      ACC: begin
        in_ready = !cheio;
        busy     = 1'b1;
        if (in_valid && (in_last || idx == 3'd3)) prox = WR;
      end
      WR: begin
        busy = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
        // the in_last word is the checksum: kept in the assembler for TERM, never written
        if (ultimo) begin
          if (!cheio) begin
            set_chk = 1'b1;
            prox    = ERR;
          end else begin
            prox = TERM;
          end
        end else
`endif
        if (end_pal == CAPACIDADE) begin
          set_ovf = 1'b1;
          prox    = ERR;
        end else begin
          imem_we = 1'b1;
          grava   = 1'b1;
          limpa   = 1'b1;
          prox    = ultimo ? TERM : ACC;
        end
      end
      TERM: begin
        busy       = 1'b1;
        imem_wdata = INSTR_HALT;
`ifdef CARREGADOR_CHECKSUM_EN
        if (palavra != acc_xor) begin
          set_chk = 1'b1;
          prox    = ERR;
        end else
`endif
        begin
          // a completely full memory needs no terminator
          imem_we = (end_pal < CAPACIDADE);
          prox    = START;
        end
      end
      START: begin
        busy       = 1'b1;
        core_start = 1'b1;
        prox       = DONE;
      end
      DONE, ERR: prox = estado;
      default:   prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_pal        <= '0;
      error_overflow <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      acc_xor        <= '0;
      error_checksum <= 1'b0;
`endif
    end else begin
      if (grava) end_pal <= end_pal + 1'b1;
      if (set_ovf) error_overflow <= 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
      if (grava) acc_xor <= acc_xor ^ palavra;
      if (set_chk) error_checksum <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for carregador_programa: a 32-word and a 4-word instance share one stimulus path.
module tb_carregador_programa;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_last, sel_b;
  logic [7:0] in_byte;

  always #5 clk = ~clk;

  logic        rdy_a, we_a, start_a, ovf_a, busy_a;
  logic [4:0]  addr_a;
  logic [31:0] wd_a;
  logic [5:0]  lw_a;
  logic        rdy_b, we_b, start_b, ovf_b, busy_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  lw_b;
`ifdef CARREGADOR_CHECKSUM_EN
  logic        chk_a, chk_b;
`endif

  carregador_programa #(.MEM_WORDS(32), .ADDR_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel_b), .in_byte(in_byte),
    .in_last(in_last), .in_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wd_a), .core_start(start_a), .loaded_words(lw_a),
    .error_overflow(ovf_a), .busy(busy_a)
`ifdef CARREGADOR_CHECKSUM_EN
    , .error_checksum(chk_a)
`endif
  );

  carregador_programa #(.MEM_WORDS(4), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel_b), .in_byte(in_byte),
    .in_last(in_last), .in_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wd_b), .core_start(start_b), .loaded_words(lw_b),
    .error_overflow(ovf_b), .busy(busy_b)
`ifdef CARREGADOR_CHECKSUM_EN
    , .error_checksum(chk_b)
`endif
  );

  logic        rdy, we, start, ovf, busy;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [5:0]  lw;
  assign rdy   = sel_b ? rdy_b   : rdy_a;
  assign we    = sel_b ? we_b    : we_a;
  assign start = sel_b ? start_b : start_a;
  assign ovf   = sel_b ? ovf_b   : ovf_a;
  assign busy  = sel_b ? busy_b  : busy_a;
  assign addr  = sel_b ? {3'b000, addr_b} : addr_a;
  assign wdata = sel_b ? wd_b : wd_a;
  assign lw    = sel_b ? {3'b000, lw_b} : lw_a;

  int          checks = 0, errors = 0, start_cnt = 0, low_cnt = 0;
  logic [4:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  stim[$];
  logic [4:0]  ea;
  logic [31:0] ed;

  // scoreboard: every write strobe must match the next expected (addr, data)
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) start_cnt++;
      if (busy && !rdy) low_cnt++;
      if (we) begin
        checks++;
        if (rdy !== 1'b0) begin
          errors++;
          $display("FAIL ready_during_write got %0b want 0", rdy);
        end
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%h want no write", addr, wdata);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (addr !== ea || wdata !== ed) begin
            errors++;
            $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h", addr, wdata, ea, ed);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);
    exp_addr.delete();
    exp_data.delete();
    start_cnt = 0;
    low_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // model: little-endian words from stim, missing bytes are zero
  task automatic push_words(input int nwords);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < stim.size()) w[8*k +: 8] = stim[4*i + k];
      push_exp(5'(i), w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    while (!rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=0 want 1 within 100 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'($urandom());
  endtask

  task automatic send_stream(input bit gaps);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], i == stim.size() - 1);
      if (gaps) repeat (1 + int'($urandom_range(0, 3) == 0)) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=1 want 0 within 200 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_done(input string nm, input int st, input int words, input logic ov);
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes got %0d want 0", nm, exp_addr.size());
    end
    checks++;
    if (start_cnt != st) begin
      errors++;
      $display("FAIL %s_core_start got %0d want %0d", nm, start_cnt, st);
    end
    checks++;
    if (lw !== 6'(words)) begin
      errors++;
      $display("FAIL %s_loaded_words got %0d want %0d", nm, lw, words);
    end
    checks++;
    if (ovf !== ov) begin
      errors++;
      $display("FAIL %s_error_overflow got %0b want %0b", nm, ovf, ov);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %0b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    sel_b = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy, we, start, ovf, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/we/start/ovf/busy=%b want 10000", {rdy, we, start, ovf, busy});
    end
    checks++;
    if (addr !== 5'd0 || wdata !== 32'h0 || lw !== 6'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d data=%h lw=%0d want 0 0 0", addr, wdata, lw);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words(input bit gaps);
    sel_b = 1'b0;
    do_reset();
    stim = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    push_exp(5'd0, 32'h00A00513);
    push_exp(5'd1, 32'h00100593);
    push_exp(5'd2, 32'h00000000);
    send_stream(gaps);
    wait_idle();
    check_done(gaps ? "gapped" : "two_words", 1, 2, 1'b0);
    checks++;
    if (low_cnt != 4) begin
      errors++;
      $display("FAIL ready_low_cycles got %0d want 4", low_cnt);
    end
  endtask

  task automatic test_partial_word();
    sel_b = 1'b0;
    do_reset();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    push_exp(5'd0, 32'hDDCCBBAA);
    push_exp(5'd1, 32'h000000EE);
    push_exp(5'd2, 32'h00000000);
    send_stream(1'b0);
    wait_idle();
    check_done("partial", 1, 2, 1'b0);
  endtask

  task automatic test_one_byte();
    sel_b = 1'b0;
    do_reset();
    stim = '{8'h7F};
    push_exp(5'd0, 32'h0000007F);
    push_exp(5'd1, 32'h00000000);
    send_stream(1'b0);
    wait_idle();
    check_done("one_byte", 1, 1, 1'b0);
    checks++;
    if (low_cnt != 3) begin
      errors++;
      $display("FAIL one_byte_ready_low got %0d want 3", low_cnt);
    end
  endtask

  task automatic test_capacity();
    sel_b = 1'b1;
    do_reset();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(8'h11 * i + 3));
    push_words(4);
    send_stream(1'b0);
    wait_idle();
    check_done("full_mem", 1, 4, 1'b0);
    checks++;
    if (low_cnt != 6) begin
      errors++;
      $display("FAIL full_mem_ready_low got %0d want 6", low_cnt);
    end
  endtask

  task automatic test_overflow();
    sel_b = 1'b1;
    do_reset();
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h25 * i + 1));
    push_words(4);
    send_stream(1'b0);
    wait_idle();
    repeat (4) @(negedge clk);
    check_done("overflow", 0, 4, 1'b1);
  endtask

  task automatic test_reset_midload();
    sel_b = 1'b0;
    do_reset();
    push_exp(5'd0, 32'h04030201);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_addr.size() != 0 || start_cnt != 0) begin
      errors++;
      $display("FAIL midload got pending=%0d starts=%0d want 0 0", exp_addr.size(), start_cnt);
    end
    do_reset();
    stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push_exp(5'd0, 32'hD4C3B2A1);
    push_exp(5'd1, 32'h00000000);
    send_stream(1'b0);
    wait_idle();
    check_done("reload", 1, 1, 1'b0);
  endtask

`ifdef CARREGADOR_CHECKSUM_EN
  task automatic test_checksum();
    sel_b = 1'b0;
    do_reset();
    stim = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h33, 8'h33};
    push_exp(5'd0, 32'h11111111);
    push_exp(5'd1, 32'h22222222);
    push_exp(5'd2, 32'h00000000);
    send_stream(1'b0);
    wait_idle();
    check_done("chk_ok", 1, 2, 1'b0);
    checks++;
    if (chk_a !== 1'b0) begin
      errors++;
      $display("FAIL chk_ok_flag got %0b want 0", chk_a);
    end
    do_reset();
    stim = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h34, 8'h33, 8'h33, 8'h33};
    push_exp(5'd0, 32'h11111111);
    push_exp(5'd1, 32'h22222222);
    send_stream(1'b0);
    wait_idle();
    check_done("chk_bad", 0, 2, 1'b0);
    checks++;
    if (chk_a !== 1'b1) begin
      errors++;
      $display("FAIL chk_bad_flag got %0b want 1", chk_a);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CARREGADOR_CHECKSUM_EN
    test_checksum();
`else
    test_two_words(1'b0);
    test_partial_word();
    test_two_words(1'b1);
    test_one_byte();
    test_capacity();
    test_overflow();
    test_reset_midload();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
